// File: rtl/color_bbox_detect.sv
// ---------------------------------------------------------------------------
// color_bbox_detect
//   Finds the bounding box of colour-matched pixels in each video frame and
//   publishes it at the next frame edge for the bounding-box overlay stage.
//
//   Ports
//     pixelclk   : pixel clock, all logic on the rising edge
//     reset_n    : asynchronous active-low reset
//     i_mask     : colour-match bit, meaningful only while i_de=1
//     i_hsync    : horizontal sync, monitored only
//     i_vsync    : vertical sync, active level set by VS_POL
//     i_de       : active-video data enable
//     hcount_l/r : left/right box column (0 when no box)
//     vcount_l/r : top/bottom box row (0 when no box)
//     o_found    : last completed frame had at least MIN_PIXELS matches
//     o_update   : one-cycle strobe when the box outputs are refreshed
//     o_pix_cnt  : matched-pixel count of the last completed frame
//
//   Input handshake: there is none; the video timing is free-running and the
//   block samples every cycle. o_update marks the single cycle in which the
//   published outputs change; between strobes they hold for a whole frame.
// ---------------------------------------------------------------------------
module color_bbox_detect #(
    parameter int MIN_PIXELS = 64,
    parameter int CNT_W      = 22,
    parameter int VS_POL     = 1
) (
    input  logic             pixelclk,
    input  logic             reset_n,
    input  logic             i_mask,
    input  logic             i_hsync,
    input  logic             i_vsync,
    input  logic             i_de,
    output logic [11:0]      hcount_l,
    output logic [11:0]      hcount_r,
    output logic [11:0]      vcount_l,
    output logic [11:0]      vcount_r,
    output logic             o_found,
    output logic             o_update,
    output logic [CNT_W-1:0] o_pix_cnt
);

    localparam logic [1:0] S_WAIT_SYNC = 2'd0;
    localparam logic [1:0] S_ACCUM     = 2'd1;
    localparam logic [1:0] S_PUBLISH   = 2'd2;

    localparam logic             VS_ACT  = (VS_POL != 0);
    localparam logic [11:0]      CRD_MAX = 12'hFFF;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PIXELS);

    // hsync carries no information this block needs.
    logic unused_hsync;
    assign unused_hsync = i_hsync;

    logic [1:0]       state_q, state_d;
    logic             vs_q, vs_qq, de_q;
    logic [11:0]      hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [11:0]      hmin_q, hmin_d, hmax_q, hmax_d;
    logic [11:0]      vmin_q, vmin_d, vmax_q, vmax_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [11:0]      hl_q, hl_d, hr_q, hr_d, vl_q, vl_d, vr_q, vr_d;
    logic             found_q, found_d, upd_q, upd_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic             fe, hit, enough;

    // Frame edge: registered vsync just became active.
    assign fe     = (vs_q == VS_ACT) && (vs_qq != VS_ACT);
    // A pixel in the frame-edge cycle belongs to neither frame.
    assign hit    = i_de && i_mask && (state_q == S_ACCUM) && !fe;
    assign enough = (cnt_q >= CNT_MIN);

    always_comb begin
        state_d = state_q;
        hmin_d  = hmin_q;
        hmax_d  = hmax_q;
        vmin_d  = vmin_q;
        vmax_d  = vmax_q;
        cnt_d   = cnt_q;
        hl_d    = hl_q;
        hr_d    = hr_q;
        vl_d    = vl_q;
        vr_d    = vr_q;
        found_d = found_q;
        pcnt_d  = pcnt_q;
        upd_d   = 1'b0;

        // Column counter: index 0 on the first de-high cycle of a line.
        if (i_de) begin
            hcnt_d = (hcnt_q == CRD_MAX) ? hcnt_q : hcnt_q + 12'd1;
        end else begin
            hcnt_d = 12'd0;
        end

        // Row counter: advances at each line end, restarts at frame edge.
        if (fe) begin
            vcnt_d = 12'd0;
        end else if (de_q && !i_de && (vcnt_q != CRD_MAX)) begin
            vcnt_d = vcnt_q + 12'd1;
        end else begin
            vcnt_d = vcnt_q;
        end

        case (state_q)
            S_WAIT_SYNC: begin
                // Partial frame after reset is discarded.
                if (fe) begin
                    hmin_d  = CRD_MAX;
                    hmax_d  = 12'd0;
                    vmin_d  = CRD_MAX;
                    vmax_d  = 12'd0;
                    cnt_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (hit) begin
                    if (hcnt_q < hmin_q) hmin_d = hcnt_q;
                    if (hcnt_q > hmax_q) hmax_d = hcnt_q;
                    if (vcnt_q < vmin_q) vmin_d = vcnt_q;
                    if (vcnt_q > vmax_q) vmax_d = vcnt_q;
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                end
                if (fe) state_d = S_PUBLISH;
            end
            S_PUBLISH: begin
                hl_d    = enough ? hmin_q : 12'd0;
                hr_d    = enough ? hmax_q : 12'd0;
                vl_d    = enough ? vmin_q : 12'd0;
                vr_d    = enough ? vmax_q : 12'd0;
                found_d = enough;
                pcnt_d  = cnt_q;
                upd_d   = 1'b1;
                hmin_d  = CRD_MAX;
                hmax_d  = 12'd0;
                vmin_d  = CRD_MAX;
                vmax_d  = 12'd0;
                cnt_d   = '0;
                state_d = S_ACCUM;
            end
            default: state_d = S_WAIT_SYNC;
        endcase
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT_SYNC;
            vs_q    <= ~VS_ACT;
            vs_qq   <= ~VS_ACT;
            de_q    <= 1'b0;
            hcnt_q  <= 12'd0;
            vcnt_q  <= 12'd0;
            hmin_q  <= CRD_MAX;
            hmax_q  <= 12'd0;
            vmin_q  <= CRD_MAX;
            vmax_q  <= 12'd0;
            cnt_q   <= '0;
            hl_q    <= 12'd0;
            hr_q    <= 12'd0;
            vl_q    <= 12'd0;
            vr_q    <= 12'd0;
            found_q <= 1'b0;
            upd_q   <= 1'b0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            vs_q    <= i_vsync;
            vs_qq   <= vs_q;
            de_q    <= i_de;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            hmin_q  <= hmin_d;
            hmax_q  <= hmax_d;
            vmin_q  <= vmin_d;
            vmax_q  <= vmax_d;
            cnt_q   <= cnt_d;
            hl_q    <= hl_d;
            hr_q    <= hr_d;
            vl_q    <= vl_d;
            vr_q    <= vr_d;
            found_q <= found_d;
            upd_q   <= upd_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign hcount_l  = hl_q;
    assign hcount_r  = hr_q;
    assign vcount_l  = vl_q;
    assign vcount_r  = vr_q;
    assign o_found   = found_q;
    assign o_update  = upd_q;
    assign o_pix_cnt = pcnt_q;

endmodule

// File: tb/tb_color_bbox_detect.sv
// ---------------------------------------------------------------------------
// tb_color_bbox_detect
//   Drives 16x8 synthetic frames into three instances sharing one stimulus:
//     d0: MIN_PIXELS=4, active-high vsync
//     d1: MIN_PIXELS=2, active-high vsync
//     d2: MIN_PIXELS=4, active-low vsync (inverted copy of the same vsync)
//   A frame-level model records the matched pixel coordinates the driver
//   sends and, at each vsync edge, schedules the published box three bench
//   cycles later. One checker compares every output of every instance on
//   every falling clock edge.
// ---------------------------------------------------------------------------
module tb_color_bbox_detect;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic vsync = 1'b0;
    logic hsync = 1'b0;
    logic de = 1'b0;
    logic mask = 1'b0;

    logic [11:0] hl [3];
    logic [11:0] hr [3];
    logic [11:0] vl [3];
    logic [11:0] vr [3];
    logic        fnd [3];
    logic        upd [3];
    logic [21:0] pc [3];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    color_bbox_detect #(.MIN_PIXELS(4), .CNT_W(22), .VS_POL(1)) d0 (
        .pixelclk(clk), .reset_n(rst_n), .i_mask(mask), .i_hsync(hsync),
        .i_vsync(vsync), .i_de(de), .hcount_l(hl[0]), .hcount_r(hr[0]),
        .vcount_l(vl[0]), .vcount_r(vr[0]), .o_found(fnd[0]),
        .o_update(upd[0]), .o_pix_cnt(pc[0]));
    color_bbox_detect #(.MIN_PIXELS(2), .CNT_W(22), .VS_POL(1)) d1 (
        .pixelclk(clk), .reset_n(rst_n), .i_mask(mask), .i_hsync(hsync),
        .i_vsync(vsync), .i_de(de), .hcount_l(hl[1]), .hcount_r(hr[1]),
        .vcount_l(vl[1]), .vcount_r(vr[1]), .o_found(fnd[1]),
        .o_update(upd[1]), .o_pix_cnt(pc[1]));
    color_bbox_detect #(.MIN_PIXELS(4), .CNT_W(22), .VS_POL(0)) d2 (
        .pixelclk(clk), .reset_n(rst_n), .i_mask(mask), .i_hsync(hsync),
        .i_vsync(~vsync), .i_de(de), .hcount_l(hl[2]), .hcount_r(hr[2]),
        .vcount_l(vl[2]), .vcount_r(vr[2]), .o_found(fnd[2]),
        .o_update(upd[2]), .o_pix_cnt(pc[2]));

    int minp [3] = '{4, 2, 4};

    // Frame-level model state
    logic [15:0] fm [8];
    bit armed = 0;
    int s_cnt, s_hmin, s_hmax, s_vmin, s_vmax;
    bit pend = 0;
    int pub_cycle = 0;
    int p_cnt, p_hmin, p_hmax, p_vmin, p_vmax;
    int e_l [3] = '{0, 0, 0};
    int e_r [3] = '{0, 0, 0};
    int e_t [3] = '{0, 0, 0};
    int e_b [3] = '{0, 0, 0};
    int e_f [3] = '{0, 0, 0};
    int e_c [3] = '{0, 0, 0};
    int e_u = 0;
    bit run_chk = 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_stats();
        s_cnt = 0; s_hmin = 4096; s_hmax = -1; s_vmin = 4096; s_vmax = -1;
    endtask

    task automatic clear_frame();
        for (int y = 0; y < 8; y++) fm[y] = 16'h0000;
    endtask

    task automatic set_box(input int x0, input int x1, input int y0, input int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) fm[y][x] = 1'b1;
    endtask

    task automatic model_reset();
        armed = 0;
        pend = 0;
        for (int k = 0; k < 3; k++) begin
            e_l[k] = 0; e_r[k] = 0; e_t[k] = 0; e_b[k] = 0; e_f[k] = 0; e_c[k] = 0;
        end
    endtask

    // One pixel-clock of stimulus, driven just after the rising edge.
    task automatic step(input logic vs, input logic d, input logic m, input int x, input int y);
        @(posedge clk);
        #1;
        vsync = vs;
        de = d;
        mask = d & m;
        hsync = ~d & ~vs;
        if (d && m && armed && rst_n) begin
            s_cnt++;
            if (x < s_hmin) s_hmin = x;
            if (x > s_hmax) s_hmax = x;
            if (y < s_vmin) s_vmin = y;
            if (y > s_vmax) s_vmax = y;
        end
    endtask

    // vsync(3) + back porch(2) + 8 lines of 16 pixels with 4-cycle gaps
    // + front porch(2). rst_row >= 0 pulses reset in the middle of that line.
    task automatic send_frame(input int rst_row);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        if (armed) begin
            pend = 1; pub_cycle = cyc + 3;
            p_cnt = s_cnt; p_hmin = s_hmin; p_hmax = s_hmax;
            p_vmin = s_vmin; p_vmax = s_vmax;
        end
        armed = 1;
        clear_stats();
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 0, 0);
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 16; x++) begin
                step(1'b0, 1'b1, fm[y][x], x, y);
                if (y == rst_row && x == 8) begin
                    rst_n = 1'b0;
                    model_reset();
                    @(negedge clk);
                    for (int k = 0; k < 3; k++) begin
                        check($sformatf("d%0d_rst_l", k), int'(hl[k]), 0);
                        check($sformatf("d%0d_rst_found", k), int'(fnd[k]), 0);
                        check($sformatf("d%0d_rst_cnt", k), int'(pc[k]), 0);
                    end
                end
                if (y == rst_row && x == 10) rst_n = 1'b1;
            end
            repeat (4) step(1'b0, 1'b0, 1'b0, 0, 0);
        end
        repeat (2) step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // Checker: every falling edge, every instance, every output.
    initial begin
        forever begin
            @(negedge clk);
            if (pend && cyc == pub_cycle) begin
                for (int k = 0; k < 3; k++) begin
                    e_f[k] = (p_cnt >= minp[k]) ? 1 : 0;
                    e_l[k] = e_f[k] ? p_hmin : 0;
                    e_r[k] = e_f[k] ? p_hmax : 0;
                    e_t[k] = e_f[k] ? p_vmin : 0;
                    e_b[k] = e_f[k] ? p_vmax : 0;
                    e_c[k] = p_cnt;
                end
                e_u = 1;
                pend = 0;
            end else begin
                e_u = 0;
            end
            if (run_chk) begin
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("d%0d_hcount_l", k), int'(hl[k]), e_l[k]);
                    check($sformatf("d%0d_hcount_r", k), int'(hr[k]), e_r[k]);
                    check($sformatf("d%0d_vcount_l", k), int'(vl[k]), e_t[k]);
                    check($sformatf("d%0d_vcount_r", k), int'(vr[k]), e_b[k]);
                    check($sformatf("d%0d_found", k), int'(fnd[k]), e_f[k]);
                    check($sformatf("d%0d_update", k), int'(upd[k]), e_u);
                    check($sformatf("d%0d_pix_cnt", k), int'(pc[k]), e_c[k]);
                end
            end
        end
    end

    task automatic lit_box(input int k, input int l, input int r, input int t,
                           input int b, input int f, input int c);
        @(negedge clk);
        check($sformatf("lit_d%0d_l", k), int'(hl[k]), l);
        check($sformatf("lit_d%0d_r", k), int'(hr[k]), r);
        check($sformatf("lit_d%0d_t", k), int'(vl[k]), t);
        check($sformatf("lit_d%0d_b", k), int'(vr[k]), b);
        check($sformatf("lit_d%0d_found", k), int'(fnd[k]), f);
        check($sformatf("lit_d%0d_cnt", k), int'(pc[k]), c);
    endtask

    initial begin
        clear_stats();
        #2 rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        lit_box(0, 0, 0, 0, 0, 0, 0);

        // F1: box cols 3..9 rows 2..5; its leading fe only arms the detector.
        clear_frame(); set_box(3, 9, 2, 5);
        send_frame(-1);
        lit_box(0, 0, 0, 0, 0, 0, 0);
        // F2: same box; its fe publishes F1.
        send_frame(-1);
        lit_box(0, 3, 9, 2, 5, 1, 28);
        lit_box(2, 3, 9, 2, 5, 1, 28);
        // F3: three matched pixels.
        clear_frame(); fm[1][1] = 1'b1; fm[1][2] = 1'b1; fm[6][5] = 1'b1;
        send_frame(-1);
        lit_box(0, 3, 9, 2, 5, 1, 28);
        // F4: corners only; its fe publishes F3.
        clear_frame(); fm[0][0] = 1'b1; fm[7][15] = 1'b1;
        send_frame(-1);
        lit_box(0, 0, 0, 0, 0, 0, 3);
        lit_box(1, 1, 5, 1, 6, 1, 3);
        // F5: box again; its fe publishes F4.
        clear_frame(); set_box(3, 9, 2, 5);
        send_frame(-1);
        lit_box(1, 0, 15, 0, 7, 1, 2);
        lit_box(0, 0, 0, 0, 0, 0, 2);
        // F6: empty; F5 box holds through it.
        clear_frame();
        send_frame(-1);
        lit_box(0, 3, 9, 2, 5, 1, 28);
        // F7: box; its fe publishes the empty F6.
        clear_frame(); set_box(3, 9, 2, 5);
        send_frame(-1);
        lit_box(0, 0, 0, 0, 0, 0, 0);
        // F8: publishes F7, then reset mid-frame.
        send_frame(3);
        lit_box(0, 0, 0, 0, 0, 0, 0);
        // F9: first fe after reset, no publish.
        send_frame(-1);
        lit_box(0, 0, 0, 0, 0, 0, 0);
        // F10: second fe after reset publishes F9.
        clear_frame();
        send_frame(-1);
        lit_box(0, 3, 9, 2, 5, 1, 28);
        lit_box(2, 3, 9, 2, 5, 1, 28);

        repeat (4) @(posedge clk);
        @(negedge clk);
        run_chk = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/color_bbox_detect.md
Name: color_bbox_detect

Overview:
- Sits directly upstream of the bounding-box overlay stage in the ISP chain.
- Consumes a 1-bit per-pixel colour-match mask and the accompanying video timing from the colour threshold stage.
- Each frame it finds the minimum and maximum active-pixel column and row of matching pixels.
- At frame end it publishes the box edges as hcount_l/hcount_r/vcount_l/vcount_r for the overlay, with a found flag and a one-cycle update strobe.

Parameters:
- MIN_PIXELS, 64: minimum matched-pixel count per frame for a box to be reported (noise rejection).
- CNT_W, 22: width of the matched-pixel counter; sized for 1920x1080.
- VS_POL, 1: active level of i_vsync (1 = active-high).

Ports:
- pixelclk  input  1  pixel clock; all logic on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_mask  input  1  colour-match bit for the current pixel; only meaningful while i_de=1.
- i_hsync  input  1  horizontal sync; monitored only, not used for counting.
- i_vsync  input  1  vertical sync, polarity per VS_POL.
- i_de  input  1  active-video data enable.
- hcount_l  output  12  left box column; 0 when no box.
- hcount_r  output  12  right box column; 0 when no box.
- vcount_l  output  12  top box row; 0 when no box.
- vcount_r  output  12  bottom box row; 0 when no box.
- o_found  output  1  last completed frame met MIN_PIXELS.
- o_update  output  1  one-cycle pulse when the box outputs are refreshed.
- o_pix_cnt  output  CNT_W  matched-pixel count of the last completed frame.

Behaviour:
- Reset (asynchronous): all outputs 0. State = WAIT_SYNC. Internal counters 0. min registers = 12'hFFF, max registers = 0.
- Frame edge (fe): cycle in which the registered i_vsync transitions from inactive to active level (per VS_POL). Detected from a one-cycle delayed copy of i_vsync.
- Column counter hcnt:
  - Pixel index within the line is 0 for the first de-high cycle.
  - Increments after each de-high cycle.
  - Clears on the cycle after de falls.
- Row counter vcnt:
  - Increments on each de falling edge.
  - Clears on fe.
  - First active line is row 0.
- Both counters saturate at 4095; no wrap.
- States:
  - WAIT_SYNC: ignore all pixels. On fe, clear accumulators and go to ACCUM. Discards the partial frame after reset.
  - ACCUM: on each cycle with i_de=1 and i_mask=1:
    - hmin = min(hmin, hcnt), hmax = max(hmax, hcnt).
    - vmin = min(vmin, vcnt), vmax = max(vmax, vcnt).
    - pix_cnt += 1, saturating at 2^CNT_W-1.
    - On fe, go to PUBLISH.
  - PUBLISH (exactly 1 cycle):
    - If pix_cnt >= MIN_PIXELS: hcount_l=hmin, hcount_r=hmax, vcount_l=vmin, vcount_r=vmax, o_found=1.
    - Otherwise all four edges = 0 and o_found=0.
    - o_pix_cnt = pix_cnt.
    - o_update=1 for this cycle only.
    - Accumulators reinitialise (min=FFF, max=0, count=0).
    - Return to ACCUM.
- Latency: outputs and o_update change 2 cycles after the i_vsync active edge (1 cycle sync register, 1 cycle PUBLISH).
- Outputs hold stable for the whole following frame; they change only in PUBLISH or on reset.
- Pixel with de=1 in the fe cycle: ignored. Pixels in the PUBLISH cycle: ignored. Sources keep de low around vsync.
- A single matched pixel at (x,y) with MIN_PIXELS<=1 gives l==r=x and top==bottom=y; the overlay then draws nothing, which is accepted.
- fe arriving while in PUBLISH cannot occur (vsync width >1 cycle); no special handling.
- Reset mid-frame: outputs clear immediately; the next box is published no earlier than the second fe after reset release.
- i_hsync is unused except for being passed to lint-clean monitoring; no output depends on it.

Test Plan:
- Reset, then two synthetic 16x8 frames (VS_POL=1, MIN_PIXELS=4) with mask=1 on columns 3..9, rows 2..5 -> after the first fe: o_update=0, outputs 0; after the second fe: o_update pulse 1 cycle, hcount_l=3, hcount_r=9, vcount_l=2, vcount_r=5, o_found=1, o_pix_cnt=28.
- Same frame geometry with 3 matched pixels -> at publish o_found=0, all edges 0, o_pix_cnt=3.
- Matched pixels at corners (0,0) and (15,7) only, MIN_PIXELS=2 -> edges 0,15,0,7; o_found=1.
- Frame N box (3,9,2,5), frame N+1 empty -> outputs hold 3/9/2/5 through frame N+1, then go to 0 with o_found=0 at the next publish.
- Assert reset_n low mid-frame after a box was published -> all outputs 0 in the same cycle. Release -> first publish occurs only after the second fe.
- VS_POL=0 with inverted vsync, same stimulus as scenario 1 -> identical results and identical 2-cycle latency from the vsync falling edge.
